spi_xfer_queue: RTL and testbench

Transaction queue that sits directly upstream of the SPI master. It buffers outgoing words in a TX FIFO and launches one SPI transaction per word with a single-cycle start pulse. When the master reports finish, it captures the received word into an RX FIFO. Both user-side ports are valid/ready streams, so software or a DMA engine never has to track per-word SPI timing.

---
 rtl/spi_xfer_queue.sv | 119 +++++++++++
 tb/tb_spi_xfer_queue.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_queue.sv
// Word-level transaction queue in front of an SPI master: TX FIFO feeds one
// launch per word, finished words land in an RX FIFO.
module spi_xfer_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [DATA_WIDTH-1:0]   tx_data,
    input  logic                    tx_valid,
    output logic                    tx_ready,
    output logic [DATA_WIDTH-1:0]   rx_data,
    output logic                    rx_valid,
    input  logic                    rx_ready,
    output logic [$clog2(DEPTH):0]  tx_count,
    output logic [$clog2(DEPTH):0]  rx_count,
    output logic                    busy,
    output logic [DATA_WIDTH-1:0]   m_data_in,
    output logic                    m_start,
    input  logic                    m_finish,
    input  logic [DATA_WIDTH-1:0]   m_data_out
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, GAP} state_t;

    state_t                state, state_next;
    logic [DATA_WIDTH-1:0] tx_mem [DEPTH];
    logic [DATA_WIDTH-1:0] rx_mem [DEPTH];
    logic [AW-1:0]         tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
    logic [GW-1:0]         gap_cnt;
    logic                  launch, tx_push, rx_push, rx_pop;

    // Both user ports: a word moves on a cycle where valid & ready are both high
    // at the rising edge; ready never looks at valid, and valid never looks at ready.
    assign tx_ready = (tx_count != FULL);
    assign rx_valid = (rx_count != '0);
    assign rx_data  = rx_valid ? rx_mem[rx_rd_ptr] : '0;
    assign busy     = (state != IDLE);
    assign tx_push  = tx_valid & tx_ready;
    assign rx_pop   = rx_valid & rx_ready;

    always_comb begin
        state_next = state;
        launch     = 1'b0;
        rx_push    = 1'b0;
        unique case (state)
            IDLE: begin
                // Launch only with a free RX slot, so the finish always has room.
                if (enable && (tx_count != '0) && (rx_count < FULL)) begin
                    launch     = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (m_finish) begin
                    rx_push    = 1'b1;
                    state_next = (GAP_CYCLES == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gap_cnt   <= '0;
            m_start   <= 1'b0;
            m_data_in <= '0;
        end else begin
            state   <= state_next;
            gap_cnt <= (state == GAP) ? gap_cnt + GW'(1) : '0;
            m_start <= launch;
            if (launch) m_data_in <= tx_mem[tx_rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= tx_data;
        if (rx_push) rx_mem[rx_wr_ptr] <= m_data_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + AW'(1);
            if (launch)  tx_rd_ptr <= tx_rd_ptr + AW'(1);
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + AW'(1);
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + AW'(1);
            unique case ({tx_push, launch})
                2'b10:   tx_count <= tx_count + CW'(1);
                2'b01:   tx_count <= tx_count - CW'(1);
                default: tx_count <= tx_count;
            endcase
            unique case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + CW'(1);
                2'b01:   rx_count <= rx_count - CW'(1);
                default: rx_count <= rx_count;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_xfer_queue.sv
// Directed bench for spi_xfer_queue with a behavioural SPI master that answers
// each start with ~m_data_in after a programmable number of cycles.
module tb_spi_xfer_queue;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int GAP   = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          enable = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready = 1'b0;
    logic [3:0]    tx_count;
    logic [3:0]    rx_count;
    logic          busy;
    logic [DW-1:0] m_data_in;
    logic          m_start;
    logic          m_finish;
    logic [DW-1:0] m_data_out;

    logic          m_fin_auto = 1'b0;
    logic          m_fin_man = 1'b0;
    logic [DW-1:0] auto_data = '0;
    logic [DW-1:0] man_data = '0;

    assign m_finish   = m_fin_auto | m_fin_man;
    assign m_data_out = m_fin_man ? man_data : auto_data;

    spi_xfer_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_count(tx_count), .rx_count(rx_count), .busy(busy),
        .m_data_in(m_data_in), .m_start(m_start),
        .m_finish(m_finish), .m_data_out(m_data_out)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail = 0;
    logic [DW-1:0] exp_q[$];

    int            cyc = 0;
    int            lat = 5;
    int            cnt = 0;
    int            wide = 0;
    bit            pend = 1'b0;
    bit            prev_start = 1'b0;
    int            start_cyc[$];
    int            fin_cyc[$];
    logic [DW-1:0] start_dat[$];

    // Master model and start/finish log, acting 1 time unit after each edge.
    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        m_fin_auto = 1'b0;
        if (m_start && prev_start) wide++;
        prev_start = m_start;
        if (!rst_n) begin
            pend = 1'b0;
        end else if (m_start) begin
            start_cyc.push_back(cyc);
            start_dat.push_back(m_data_in);
            pend = 1'b1;
            cnt  = lat;
        end else if (pend) begin
            if (cnt <= 1) begin
                m_fin_auto = 1'b1;
                auto_data  = ~m_data_in;
                fin_cyc.push_back(cyc);
                pend = 1'b0;
            end else begin
                cnt--;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        int n = 0;
        tx_data  = w;
        tx_valid = 1'b1;
        while (!tx_ready && n < 200) begin
            tick();
            n++;
        end
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic wait_finish();
        int n = 0;
        while (!m_finish && n < 300) begin
            tick();
            n++;
        end
        check("finish_seen", 32'(m_finish), 32'd1);
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 2000) begin
            if (rx_valid && rx_ready) check("rx_data_order", rx_data, exp_q.pop_front());
            tick();
            guard++;
        end
        check("drain_done", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int n0, nf0, c0, n;
        bit ok;

        // Reset state
        #1 rst_n = 1'b0;
        repeat (3) tick();
        check("rst_m_start", 32'(m_start), 32'd0);
        check("rst_m_data_in", m_data_in, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data", rx_data, 32'd0);
        check("rst_tx_count", 32'(tx_count), 32'd0);
        check("rst_rx_count", 32'(rx_count), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        rst_n = 1'b1;
        tick();
        tick();

        // Single word, 40-cycle master
        enable = 1'b1;
        lat = 40;
        n0 = start_dat.size();
        nf0 = fin_cyc.size();
        push_word(32'hA5A5_0001);
        check("t1_tx_count_c1", 32'(tx_count), 32'd1);
        check("t1_no_start_c1", 32'(m_start), 32'd0);
        tick();
        check("t1_start_c2", 32'(m_start), 32'd1);
        check("t1_m_data_in", m_data_in, 32'hA5A5_0001);
        check("t1_busy", 32'(busy), 32'd1);
        tick();
        check("t1_start_width", 32'(m_start), 32'd0);
        wait_finish();
        check("t1_latency", (fin_cyc.size() > nf0 && start_cyc.size() > n0) ?
              32'(fin_cyc[nf0] - start_cyc[n0]) : 32'hFFFF_FFFF, 32'd40);
        tick();
        check("t1_rx_valid", 32'(rx_valid), 32'd1);
        check("t1_rx_data", rx_data, 32'h5A5A_FFFE);
        check("t1_busy_gap1", 32'(busy), 32'd1);
        tick();
        check("t1_busy_gap2", 32'(busy), 32'd1);
        tick();
        check("t1_busy_idle", 32'(busy), 32'd0);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        check("t1_rx_popped", 32'(rx_count), 32'd0);

        // Burst fill with enable low, then release
        enable = 1'b0;
        lat = 3;
        for (int i = 0; i < 8; i++) begin
            push_word(32'hB000_0000 + 32'(i));
            exp_q.push_back(~(32'hB000_0000 + 32'(i)));
        end
        check("t2_full_ready", 32'(tx_ready), 32'd0);
        check("t2_full_count", 32'(tx_count), 32'd8);
        tx_data  = 32'hB000_0008;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        check("t2_overflow_count", 32'(tx_count), 32'd8);
        n0 = start_dat.size();
        nf0 = fin_cyc.size();
        rx_ready = 1'b1;
        enable = 1'b1;
        drain();
        repeat (6) tick();
        check("t2_start_count", 32'(start_dat.size() - n0), 32'd8);
        check("t2_tx_empty", 32'(tx_count), 32'd0);
        if (start_dat.size() >= n0 + 8 && fin_cyc.size() >= nf0 + 8) begin
            for (int i = 0; i < 8; i++)
                check("t2_start_order", start_dat[n0 + i], 32'hB000_0000 + 32'(i));
            for (int i = 1; i < 8; i++) begin
                ok = (start_cyc[n0 + i] - fin_cyc[nf0 + i - 1]) >= GAP + 2;
                check("t2_spacing", 32'(ok), 32'd1);
            end
        end

        // RX backpressure with 10 words
        rx_ready = 1'b0;
        n0 = start_dat.size();
        for (int i = 0; i < 10; i++) begin
            push_word(32'hC000_0000 + 32'(i));
            exp_q.push_back(~(32'hC000_0000 + 32'(i)));
        end
        repeat (120) tick();
        check("t3_rx_full", 32'(rx_count), 32'd8);
        check("t3_starts", 32'(start_dat.size() - n0), 32'd8);
        check("t3_tx_left", 32'(tx_count), 32'd2);
        check("t3_idle", 32'(busy), 32'd0);
        c0 = start_dat.size();
        repeat (20) tick();
        check("t3_no_start", 32'(start_dat.size() - c0), 32'd0);
        check("t3_head", rx_data, exp_q.pop_front());
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        check("t3_pop_count", 32'(rx_count), 32'd7);
        check("t3_no_start_p1", 32'(m_start), 32'd0);
        tick();
        check("t3_relaunch", 32'(m_start), 32'd1);
        check("t3_relaunch_data", m_data_in, 32'hC000_0008);
        rx_ready = 1'b1;
        drain();
        repeat (10) tick();

        // Push in launch cycle, pop in finish cycle
        rx_ready = 1'b0;
        enable = 1'b0;
        push_word(32'hD000_0000);
        exp_q.push_back(~32'hD000_0000);
        enable   = 1'b1;
        tx_data  = 32'hD000_0001;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        exp_q.push_back(~32'hD000_0001);
        check("t4_tx_count_same", 32'(tx_count), 32'd1);
        check("t4_start", 32'(m_start), 32'd1);
        check("t4_start_data", m_data_in, 32'hD000_0000);
        wait_finish();
        tick();
        check("t4_rx_one", 32'(rx_count), 32'd1);
        wait_finish();
        check("t4_rx_before", 32'(rx_count), 32'd1);
        check("t4_rx_head0", rx_data, exp_q.pop_front());
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        check("t4_rx_count_same", 32'(rx_count), 32'd1);
        check("t4_rx_head1", rx_data, exp_q.pop_front());
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        check("t4_rx_empty", 32'(rx_count), 32'd0);
        repeat (5) tick();

        // Spurious finish in IDLE and in GAP
        m_fin_man = 1'b1;
        man_data  = 32'hDEAD_BEEF;
        tick();
        m_fin_man = 1'b0;
        check("t5_idle_rx_count", 32'(rx_count), 32'd0);
        check("t5_idle_busy", 32'(busy), 32'd0);
        push_word(32'hE000_0000);
        wait_finish();
        tick();
        m_fin_man = 1'b1;
        tick();
        m_fin_man = 1'b0;
        check("t5_gap_rx_count", 32'(rx_count), 32'd1);
        check("t5_gap_busy", 32'(busy), 32'd1);
        check("t5_gap_rx_data", rx_data, ~32'hE000_0000);
        tick();
        check("t5_back_idle", 32'(busy), 32'd0);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        check("t5_rx_empty", 32'(rx_count), 32'd0);

        // Reset in the middle of WAIT
        enable = 1'b0;
        lat = 40;
        for (int i = 0; i < 3; i++) push_word(32'hF000_0000 + 32'(i));
        enable = 1'b1;
        n = 0;
        while (!m_start && n < 20) begin
            tick();
            n++;
        end
        check("t6_start_seen", 32'(m_start), 32'd1);
        repeat (20) tick();
        rst_n = 1'b0;
        #1;
        check("t6_rst_m_start", 32'(m_start), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_tx_count", 32'(tx_count), 32'd0);
        check("t6_rst_rx_valid", 32'(rx_valid), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        c0 = start_dat.size();
        repeat (10) tick();
        check("t6_no_start", 32'(start_dat.size() - c0), 32'd0);
        check("t6_idle", 32'(busy), 32'd0);
        lat = 3;
        rx_ready = 1'b1;
        push_word(32'h1234_5678);
        exp_q.push_back(~32'h1234_5678);
        tick();
        check("t6_new_start", 32'(m_start), 32'd1);
        check("t6_new_data", m_data_in, 32'h1234_5678);
        drain();
        repeat (5) tick();

        check("start_pulse_width", 32'(wide), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
